// File: rtl/lbp_seq_ctrl.sv
// lbp_seq_ctrl: sequencer for the LBP datapath.
//   Loads a raster-order pixel stream into a single-port image SRAM, then walks
//   every pixel: interior pixels get 9 neighbourhood reads (centre first), border
//   pixels are emitted as zero without touching the SRAM.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : pixel strobe during load (ignored once processing starts)
//   mem_cen_n    : SRAM chip enable (active low)
//   mem_wen_n    : SRAM write enable (active low, 1 = read)
//   mem_addr     : SRAM address, row*IMG_W+col
//   nb_vld/nb_idx: SRAM read data valid and the 3x3 slot it belongs to
//   out_strobe   : datapath result valid for the current pixel
//   out_zero     : qualifies out_strobe, result forced to zero (border pixel)
//   busy, done   : frame in progress / one-cycle end-of-frame pulse
module lbp_seq_ctrl #(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          mem_cen_n,
  output logic          mem_wen_n,
  output logic [AW-1:0] mem_addr,
  output logic          nb_vld,
  output logic [3:0]    nb_idx,
  output logic          out_strobe,
  output logic          out_zero,
  output logic          busy,
  output logic          done
);

  localparam int unsigned RW   = $clog2(IMG_H);
  localparam int unsigned CW   = $clog2(IMG_W);
  localparam int unsigned NPIX = IMG_W * IMG_H;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, READ, WAIT, EMIT, FIN} state_t;

  state_t        state;
  logic [AW:0]   load_cnt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [3:0]    k;

  logic          is_border_c;
  logic          is_last_c;
  logic [3:0]    slot_c;
  logic [RW-1:0] nb_row_c;
  logic [CW-1:0] nb_col_c;
  logic [AW-1:0] rd_addr_c;

  // Position classification of the current pixel
  assign is_border_c = (row == '0) || (row == RW'(IMG_H - 1)) ||
                       (col == '0) || (col == CW'(IMG_W - 1));
  assign is_last_c   = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  // Address of the read issued on the next edge: slot 0 from SCAN, slot k+1 from READ
  always_comb begin
    slot_c   = (state == READ) ? k + 4'd1 : 4'd0;
    nb_row_c = row;
    nb_col_c = col;
    case (slot_c)
      4'd1, 4'd2, 4'd3: nb_row_c = row - RW'(1);
      4'd6, 4'd7, 4'd8: nb_row_c = row + RW'(1);
      default:          nb_row_c = row;
    endcase
    case (slot_c)
      4'd1, 4'd4, 4'd6: nb_col_c = col - CW'(1);
      4'd3, 4'd5, 4'd8: nb_col_c = col + CW'(1);
      default:          nb_col_c = col;
    endcase
    rd_addr_c = AW'(nb_row_c) * AW'(IMG_W) + AW'(nb_col_c);
  end

  // Sequencer: state, counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_cnt   <= '0;
      row        <= '0;
      col        <= '0;
      k          <= '0;
      mem_cen_n  <= 1'b1;
      mem_wen_n  <= 1'b1;
      mem_addr   <= '0;
      nb_vld     <= 1'b0;
      nb_idx     <= '0;
      out_strobe <= 1'b0;
      out_zero   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Single-cycle strobes and the SRAM enable default to inactive
      mem_cen_n  <= 1'b1;
      mem_wen_n  <= 1'b1;
      nb_vld     <= 1'b0;
      out_strobe <= 1'b0;
      done       <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            mem_cen_n <= 1'b0;
            mem_wen_n <= 1'b0;
            mem_addr  <= AW'(load_cnt);
            load_cnt  <= load_cnt + (AW + 1)'(1);
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end

        LOAD: begin
          // load_cnt reaches NPIX in the cycle the final write is on the bus
          if (load_cnt == (AW + 1)'(NPIX)) begin
            row   <= '0;
            col   <= '0;
            state <= SCAN;
          end else if (in_valid) begin
            mem_cen_n <= 1'b0;
            mem_wen_n <= 1'b0;
            mem_addr  <= AW'(load_cnt);
            load_cnt  <= load_cnt + (AW + 1)'(1);
          end
        end

        SCAN: begin
          if (is_border_c) begin
            out_strobe <= 1'b1;
            out_zero   <= 1'b1;
            state      <= EMIT;
          end else begin
            mem_cen_n <= 1'b0;
            mem_addr  <= rd_addr_c;
            k         <= '0;
            state     <= READ;
          end
        end

        READ: begin
          // Data for read k returns one cycle later
          nb_vld <= 1'b1;
          nb_idx <= k;
          if (k == 4'd8) begin
            state <= WAIT;
          end else begin
            mem_cen_n <= 1'b0;
            mem_addr  <= rd_addr_c;
            k         <= k + 4'd1;
          end
        end

        WAIT: begin
          out_strobe <= 1'b1;
          out_zero   <= 1'b0;
          state      <= EMIT;
        end

        EMIT: begin
          out_zero <= 1'b0;
          if (is_last_c) begin
            row   <= '0;
            col   <= '0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            state <= SCAN;
          end
        end

        FIN: begin
          busy     <= 1'b0;
          load_cnt <= '0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_seq_ctrl.sv
// Bench for lbp_seq_ctrl: builds the expected per-cycle output trace of a whole
// frame from the behavioural rules (write one cycle after each pixel strobe, then
// raster walk with 2-cycle border / 12-cycle interior pixels) and compares the
// DUT against it every cycle, plus literal frame-level counts.
module tb_lbp_seq_ctrl;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int AW = 8;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          mem_cen_n;
  logic          mem_wen_n;
  logic [AW-1:0] mem_addr;
  logic          nb_vld;
  logic [3:0]    nb_idx;
  logic          out_strobe;
  logic          out_zero;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  lbp_seq_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .mem_cen_n  (mem_cen_n),
    .mem_wen_n  (mem_wen_n),
    .mem_addr   (mem_addr),
    .nb_vld     (nb_vld),
    .nb_idx     (nb_idx),
    .out_strobe (out_strobe),
    .out_zero   (out_zero),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic cen_n;
    logic wen_n;
    int   addr;
    logic nbv;
    int   nbi;
    logic stb;
    logic zero;
    logic busy;
    logic done;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t tr[$];
  bit   vin[$];
  int   rst_idx;

  // Neighbour offsets by slot: C, TL, T, TR, L, R, BL, B, BR
  int dr[9]     = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
  int dc[9]     = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
  int exp_rd[9] = '{17, 0, 1, 2, 16, 18, 32, 33, 34};

  function automatic exp_t mk(input logic b);
    exp_t e;
    e.cen_n = 1'b1; e.wen_n = 1'b1; e.addr = 0; e.nbv = 1'b0; e.nbi = 0;
    e.stb = 1'b0; e.zero = 1'b0; e.busy = b; e.done = 1'b0;
    return e;
  endfunction

  function automatic bit pat_v(input int pat, input int t);
    case (pat)
      0:       return (t % 2) == 0;
      1:       return 1'b1;
      default: return (t % 3) != 2;
    endcase
  endfunction

  task automatic chk_val(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_reset(input string name);
    n_tests++;
    if (mem_cen_n !== 1'b1 || mem_wen_n !== 1'b1 || mem_addr !== '0 ||
        nb_vld !== 1'b0 || nb_idx !== 4'd0 || out_strobe !== 1'b0 ||
        out_zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got cen=%b wen=%b addr=%0d nbv=%b nbi=%0d stb=%b zero=%b busy=%b done=%b, want all reset values",
               name, mem_cen_n, mem_wen_n, mem_addr, nb_vld, nb_idx, out_strobe, out_zero, busy, done);
    end
  endtask

  task automatic chk_cycle(input exp_t e, input int c);
    bit ok;
    ok = (mem_cen_n === e.cen_n) && (mem_wen_n === e.wen_n) && (nb_vld === e.nbv) &&
         (out_strobe === e.stb) && (busy === e.busy) && (done === e.done);
    if (!e.cen_n && int'(mem_addr) != e.addr) ok = 1'b0;
    if (e.nbv && int'(nb_idx) != e.nbi) ok = 1'b0;
    if (e.stb && out_zero !== e.zero) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle_trace c=%0d: got cen=%b wen=%b addr=%0d nbv=%b nbi=%0d stb=%b zero=%b busy=%b done=%b, want cen=%b wen=%b addr=%0d nbv=%b nbi=%0d stb=%b zero=%b busy=%b done=%b",
               c, mem_cen_n, mem_wen_n, mem_addr, nb_vld, nb_idx, out_strobe, out_zero, busy, done,
               e.cen_n, e.wen_n, e.addr, e.nbv, e.nbi, e.stb, e.zero, e.busy, e.done);
    end
  endtask

  // Expected trace of one frame; cycle 0 is the idle cycle carrying the first pixel strobe
  task automatic build_frame(input int pat, input bit hold);
    exp_t e;
    int   cnt;
    int   t;
    tr.delete();
    vin.delete();
    rst_idx = -1;
    cnt = 0;
    t   = 0;
    while (cnt < N) begin
      vin.push_back(pat_v(pat, t));
      if (pat_v(pat, t)) cnt++;
      t++;
    end
    tr.push_back(mk(1'b0));
    cnt = 0;
    foreach (vin[i]) begin
      e = mk(1'b1);
      if (vin[i]) begin
        e.cen_n = 1'b0; e.wen_n = 1'b0; e.addr = cnt; cnt++;
      end
      tr.push_back(e);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        tr.push_back(mk(1'b1));
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          e = mk(1'b1); e.stb = 1'b1; e.zero = 1'b1;
          tr.push_back(e);
        end else begin
          for (int k = 0; k < 9; k++) begin
            if (r == 5 && c == 5 && k == 4) rst_idx = tr.size();
            e = mk(1'b1);
            e.cen_n = 1'b0;
            e.addr  = (r + dr[k]) * W + (c + dc[k]);
            if (k > 0) begin e.nbv = 1'b1; e.nbi = k - 1; end
            tr.push_back(e);
          end
          e = mk(1'b1); e.nbv = 1'b1; e.nbi = 8;
          tr.push_back(e);
          e = mk(1'b1); e.stb = 1'b1; e.zero = 1'b0;
          tr.push_back(e);
        end
      end
    end
    e = mk(1'b1); e.done = 1'b1;
    tr.push_back(e);
    while (vin.size() < tr.size() - 1) vin.push_back(hold);
    vin.push_back(1'b0);
  endtask

  // Entered and left at posedge+1; stops early (before driving) at stop_at
  task automatic run_frame(input int stop_at, input bit measure);
    int wr = 0, stb = 0, zer = 0;
    int last_wr = -1, last_stb = -1, first_stb = -1, first_zero = 0, done_c = -1;
    int rd[$];
    for (int c = 0; c < tr.size(); c++) begin
      chk_cycle(tr[c], c);
      if (!mem_cen_n && !mem_wen_n) begin wr++; last_wr = c; end
      if (!mem_cen_n && mem_wen_n) rd.push_back(int'(mem_addr));
      if (out_strobe) begin
        if (first_stb < 0) begin first_stb = c; first_zero = int'(out_zero); end
        stb++;
        if (out_zero) zer++;
        last_stb = c;
      end
      if (done) done_c = c;
      if (c == stop_at) return;
      in_valid = vin[c];
      @(posedge clk);
      #1;
    end
    if (measure) begin
      chk_val("write_count", wr, N);
      chk_val("strobe_count", stb, N);
      chk_val("zero_strobe_count", zer, 60);
      chk_val("proc_cycles", last_stb - last_wr, 2472);
      chk_val("done_after_last_strobe", done_c - last_stb, 1);
      chk_val("first_strobe_latency", first_stb - last_wr, 2);
      chk_val("first_strobe_zero", first_zero, 1);
      chk_val("busy_after_done", int'(busy), 0);
      chk_val("read_count_min", int'(rd.size() >= 9), 1);
      if (rd.size() >= 9)
        for (int i = 0; i < 9; i++) chk_val("pixel11_read_order", rd[i], exp_rd[i]);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #12;
    chk_reset("power_on_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load with 1/0 gaps, quiet in_valid during processing
    build_frame(0, 1'b0);
    run_frame(-1, 1'b1);

    // Back-to-back frame, continuous load, in_valid held high during processing
    build_frame(1, 1'b1);
    run_frame(-1, 1'b1);

    // Abandon a frame mid-READ of pixel (5,5)
    build_frame(2, 1'b0);
    run_frame(rst_idx, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_reset("reset_during_read");
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh frame after the abort restarts at address 0
    build_frame(0, 1'b0);
    run_frame(-1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
